msrh_alu_issue_unit: RTL and testbench

Reservation station and scheduler directly upstream of the ALU pipe. It accepts renamed ALU and mul/div instructions from dispatch and holds them until both sources are ready. Source wakeup comes from the early-write and physical-write buses. Each cycle it selects the oldest ready entry and drives it to the ALU pipe as a registered issue packet plus a one-hot entry index; the entry is freed when the ALU reports done for that index.

---
 rtl/msrh_pkg.sv | 50 +++++
 rtl/msrh_rs_age_matrix.sv | 42 ++++
 rtl/msrh_alu_issue_unit.sv | 192 +++++++++++++++++++
 tb/tb_msrh_alu_issue_unit.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/msrh_pkg.sv
// Shared types for the msrh core: rename ids, wakeup buses, issue packets.
// Also holds the reservation-station entry state used by the ALU scheduler.
package msrh_pkg;

    localparam int TGT_BUS_SIZE = 2;
    localparam int RNID_W       = 6;

    typedef logic [RNID_W-1:0] rnid_t;

    typedef enum logic {
        GPR = 1'b0,
        FPR = 1'b1
    } reg_t;

    typedef struct packed {
        logic  valid;
        reg_t  rd_type;
        rnid_t rd_rnid;
    } early_wr_t;

    typedef struct packed {
        logic  valid;
        reg_t  rd_type;
        rnid_t rd_rnid;
    } phy_wr_t;

    typedef struct packed {
        logic  valid;
        reg_t  regtype;
        rnid_t rnid;
        logic  ready;
    } src_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] inst;
        logic        rd_valid;
        reg_t        rd_type;
        rnid_t       rd_rnid;
        src_t        rs1;
        src_t        rs2;
    } issue_t;

    typedef enum logic [1:0] {
        RS_FREE   = 2'd0,
        RS_WAIT   = 2'd1,
        RS_ISSUED = 2'd2
    } rs_state_t;

endpackage

// File: rtl/msrh_rs_age_matrix.sv
// Allocation-order matrix: grants the oldest requesting entry.
// Ports: i_alloc_oh new entry, i_valid non-FREE mask, i_req ready set, o_grant one-hot.
module msrh_rs_age_matrix #(
    parameter int ENTRY_SIZE = 8
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic [ENTRY_SIZE-1:0] i_alloc_oh,
    input  logic [ENTRY_SIZE-1:0] i_valid,
    input  logic [ENTRY_SIZE-1:0] i_req,
    output logic [ENTRY_SIZE-1:0] o_grant
);

    // r_older[i][j] set: entry j was allocated before entry i.
    logic [ENTRY_SIZE-1:0] r_older [ENTRY_SIZE];

    // A new entry is younger than everything live; its column is cleared
    // so stale bits from a previous occupant never block older entries.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            for (int i = 0; i < ENTRY_SIZE; i++) begin
                r_older[i] <= '0;
            end
        end else begin
            for (int i = 0; i < ENTRY_SIZE; i++) begin
                if (i_alloc_oh[i]) begin
                    r_older[i] <= i_valid;
                end else begin
                    r_older[i] <= r_older[i] & ~i_alloc_oh;
                end
            end
        end
    end

    always_comb begin
        o_grant = '0;
        for (int i = 0; i < ENTRY_SIZE; i++) begin
            o_grant[i] = i_req[i] & ~(|(r_older[i] & i_req));
        end
    end

endmodule

// File: rtl/msrh_alu_issue_unit.sv
// ALU reservation station: holds renamed ops until sources wake, issues oldest ready.
// Ports: dispatch in/ready, early/phy wakeup buses, stall, done, flush, issue out, count.
module msrh_alu_issue_unit
    import msrh_pkg::*;
#(
    parameter int ENTRY_SIZE = 8,
    parameter int WAKE_SIZE  = TGT_BUS_SIZE
) (
    input  logic                            i_clk,
    input  logic                            i_reset_n,
    input  logic                            i_disp_valid,
    input  issue_t                          i_disp_issue,
    output logic                            o_disp_ready,
    input  early_wr_t                       i_early_wr [WAKE_SIZE],
    input  phy_wr_t                         i_phy_wr [WAKE_SIZE],
    input  logic                            i_muldiv_stall,
    input  logic                            i_done_valid,
    input  logic [ENTRY_SIZE-1:0]           i_done_index_oh,
    input  logic                            i_flush,
    output issue_t                          o_issue,
    output logic [ENTRY_SIZE-1:0]           o_issue_index,
    output logic [$clog2(ENTRY_SIZE+1)-1:0] o_entry_count
);

    localparam int CNT_W = $clog2(ENTRY_SIZE + 1);

    rs_state_t r_state [ENTRY_SIZE];
    issue_t    r_entry [ENTRY_SIZE];

    logic [ENTRY_SIZE-1:0] w_free;
    logic [ENTRY_SIZE-1:0] w_busy;
    logic [ENTRY_SIZE-1:0] w_ready;
    logic [ENTRY_SIZE-1:0] w_req;
    logic [ENTRY_SIZE-1:0] w_grant;
    logic [ENTRY_SIZE-1:0] w_alloc_oh;
    logic                  w_alloc;
    issue_t                w_disp_woken;
    issue_t                w_sel_issue;
    src_t                  w_rs1_woken [ENTRY_SIZE];
    src_t                  w_rs2_woken [ENTRY_SIZE];

    // rnid 0 is the hardwired zero register and never needs a wakeup.
    function automatic src_t wake(
        input src_t      s,
        input early_wr_t ew [WAKE_SIZE],
        input phy_wr_t   pw [WAKE_SIZE]
    );
        src_t o;
        o = s;
        if (s.valid && (s.rnid == '0)) begin
            o.ready = 1'b1;
        end
        for (int b = 0; b < WAKE_SIZE; b++) begin
            if (s.valid && ew[b].valid &&
                (ew[b].rd_type == s.regtype) &&
                (ew[b].rd_rnid == s.rnid)) begin
                o.ready = 1'b1;
            end
            if (s.valid && pw[b].valid &&
                (pw[b].rd_type == s.regtype) &&
                (pw[b].rd_rnid == s.rnid)) begin
                o.ready = 1'b1;
            end
        end
        return o;
    endfunction

    always_comb begin
        w_free  = '0;
        w_ready = '0;
        for (int i = 0; i < ENTRY_SIZE; i++) begin
            w_free[i]  = (r_state[i] == RS_FREE);
            w_ready[i] = (r_state[i] == RS_WAIT) &&
                         (!r_entry[i].rs1.valid || r_entry[i].rs1.ready) &&
                         (!r_entry[i].rs2.valid || r_entry[i].rs2.ready);
        end
    end

    assign w_busy       = ~w_free;
    assign w_req        = i_muldiv_stall ? '0 : w_ready;
    assign o_disp_ready = |w_free;
    assign w_alloc      = i_disp_valid & o_disp_ready & ~i_flush;

    // Lowest-index FREE entry wins: later iterations overwrite earlier ones.
    always_comb begin
        w_alloc_oh = '0;
        for (int i = ENTRY_SIZE - 1; i >= 0; i--) begin
            if (w_free[i]) begin
                w_alloc_oh    = '0;
                w_alloc_oh[i] = w_alloc;
            end
        end
    end

    always_comb begin
        o_entry_count = '0;
        for (int i = 0; i < ENTRY_SIZE; i++) begin
            o_entry_count = o_entry_count + CNT_W'(w_busy[i]);
        end
    end

    always_comb begin
        w_disp_woken     = i_disp_issue;
        w_disp_woken.rs1 = wake(i_disp_issue.rs1, i_early_wr, i_phy_wr);
        w_disp_woken.rs2 = wake(i_disp_issue.rs2, i_early_wr, i_phy_wr);
        for (int i = 0; i < ENTRY_SIZE; i++) begin
            w_rs1_woken[i] = wake(r_entry[i].rs1, i_early_wr, i_phy_wr);
            w_rs2_woken[i] = wake(r_entry[i].rs2, i_early_wr, i_phy_wr);
        end
    end

    msrh_rs_age_matrix #(
        .ENTRY_SIZE (ENTRY_SIZE)
    ) u_age (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_alloc_oh (w_alloc_oh),
        .i_valid    (w_busy),
        .i_req      (w_req),
        .o_grant    (w_grant)
    );

    always_comb begin
        w_sel_issue = '0;
        for (int i = 0; i < ENTRY_SIZE; i++) begin
            if (w_grant[i]) begin
                w_sel_issue = r_entry[i];
            end
        end
        w_sel_issue.valid = |w_grant;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            for (int i = 0; i < ENTRY_SIZE; i++) begin
                r_state[i] <= RS_FREE;
                r_entry[i] <= '0;
            end
        end else if (i_flush) begin
            for (int i = 0; i < ENTRY_SIZE; i++) begin
                r_state[i] <= RS_FREE;
            end
        end else begin
            for (int i = 0; i < ENTRY_SIZE; i++) begin
                if (w_alloc_oh[i]) begin
                    r_state[i] <= RS_WAIT;
                    r_entry[i] <= w_disp_woken;
                end else begin
                    unique case (r_state[i])
                        RS_WAIT: begin
                            r_entry[i].rs1 <= w_rs1_woken[i];
                            r_entry[i].rs2 <= w_rs2_woken[i];
                            if (w_grant[i]) begin
                                r_state[i] <= RS_ISSUED;
                            end
                        end
                        RS_ISSUED: begin
                            if (i_done_valid && i_done_index_oh[i]) begin
                                r_state[i] <= RS_FREE;
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n || i_flush) begin
            o_issue       <= '0;
            o_issue_index <= '0;
        end else begin
            o_issue       <= w_sel_issue;
            o_issue_index <= w_grant;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge i_clk) begin
        if (i_reset_n && !i_flush && i_done_valid) begin
            for (int i = 0; i < ENTRY_SIZE; i++) begin
                if (i_done_index_oh[i] && (r_state[i] != RS_ISSUED)) begin
                    $fatal(1, "done for entry %0d which is not issued", i);
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_msrh_alu_issue_unit.sv
// Bench for msrh_alu_issue_unit: sequence-number model plus directed scenarios.
// Compares every cycle on the falling edge; literal checks pin key timings.
module tb_msrh_alu_issue_unit;
    import msrh_pkg::*;

    logic      clk = 1'b0;
    logic      rst_n;
    logic      disp_valid;
    issue_t    disp_issue;
    logic      disp_ready;
    early_wr_t ew [TGT_BUS_SIZE];
    phy_wr_t   pw [TGT_BUS_SIZE];
    logic      stall;
    logic      done_valid;
    logic [7:0] done_oh;
    logic      flush;
    issue_t    iss;
    logic [7:0] iss_idx;
    logic [3:0] cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    msrh_alu_issue_unit dut (
        .i_clk           (clk),
        .i_reset_n       (rst_n),
        .i_disp_valid    (disp_valid),
        .i_disp_issue    (disp_issue),
        .o_disp_ready    (disp_ready),
        .i_early_wr      (ew),
        .i_phy_wr        (pw),
        .i_muldiv_stall  (stall),
        .i_done_valid    (done_valid),
        .i_done_index_oh (done_oh),
        .i_flush         (flush),
        .o_issue         (iss),
        .o_issue_index   (iss_idx),
        .o_entry_count   (cnt)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h @%0t", nm, act, exp, $time);
        end
    endtask

    // Model: each live entry carries an allocation sequence number;
    // the ready entry with the smallest number is the oldest.
    bit     m_busy [8];
    bit     m_iss  [8];
    int     m_seq  [8];
    issue_t m_pkt  [8];
    int     seq_ctr = 0;
    issue_t e_pkt = '0;
    logic [7:0] e_idx = '0;

    function automatic logic hit(input logic v, input reg_t t, input rnid_t r);
        if (!v) return 1'b0;
        if (r == 0) return 1'b1;
        for (int b = 0; b < TGT_BUS_SIZE; b++) begin
            if (ew[b].valid && ew[b].rd_type == t && ew[b].rd_rnid == r) return 1'b1;
            if (pw[b].valid && pw[b].rd_type == t && pw[b].rd_rnid == r) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic issue_t woken(input issue_t p);
        issue_t q = p;
        if (hit(p.rs1.valid, p.rs1.regtype, p.rs1.rnid)) q.rs1.ready = 1'b1;
        if (hit(p.rs2.valid, p.rs2.regtype, p.rs2.rnid)) q.rs2.ready = 1'b1;
        return q;
    endfunction

    function automatic bit is_rdy(input issue_t p);
        return (!p.rs1.valid || p.rs1.ready) && (!p.rs2.valid || p.rs2.ready);
    endfunction

    task automatic model_step();
        bit fr [8];
        int sel;
        int a;
        if (!rst_n || flush) begin
            for (int i = 0; i < 8; i++) begin
                m_busy[i] = 0;
                m_iss[i]  = 0;
            end
            e_pkt = '0;
            e_idx = '0;
        end else begin
            sel = -1;
            for (int i = 0; i < 8; i++) fr[i] = !m_busy[i];
            if (!stall) begin
                for (int i = 0; i < 8; i++) begin
                    if (m_busy[i] && !m_iss[i] && is_rdy(m_pkt[i]) &&
                        (sel < 0 || m_seq[i] < m_seq[sel])) sel = i;
                end
            end
            if (sel >= 0) begin
                e_pkt = m_pkt[sel];
                e_pkt.valid = 1'b1;
                e_idx = 8'b1 << sel;
            end else begin
                e_pkt = '0;
                e_idx = '0;
            end
            for (int i = 0; i < 8; i++) begin
                if (done_valid && done_oh[i] && m_iss[i]) begin
                    m_busy[i] = 0;
                    m_iss[i]  = 0;
                end
            end
            for (int i = 0; i < 8; i++) begin
                if (m_busy[i] && !m_iss[i]) m_pkt[i] = woken(m_pkt[i]);
            end
            if (sel >= 0) m_iss[sel] = 1;
            if (disp_valid) begin
                a = -1;
                for (int i = 0; i < 8; i++) if (fr[i] && a < 0) a = i;
                if (a >= 0) begin
                    m_pkt[a]  = woken(disp_issue);
                    m_busy[a] = 1;
                    m_iss[a]  = 0;
                    m_seq[a]  = seq_ctr++;
                end
            end
        end
    endtask

    initial begin
        int live;
        @(posedge clk);
        forever begin
            @(negedge clk);
            live = 0;
            for (int i = 0; i < 8; i++) live += int'(m_busy[i]);
            chk("issue_valid", 64'(iss.valid), 64'(e_pkt.valid));
            chk("issue_pkt", 64'(iss), 64'(e_pkt));
            chk("issue_index", 64'(iss_idx), 64'(e_idx));
            chk("entry_count", 64'(cnt), 64'(live));
            chk("disp_ready", 64'(disp_ready), 64'(live < 8));
            model_step();
        end
    end

    function automatic issue_t mk(input logic [31:0] inst,
                                  input logic s1v, input int s1r,
                                  input logic s2v, input int s2r);
        issue_t p = '0;
        p.valid       = 1'b1;
        p.inst        = inst;
        p.rd_valid    = 1'b1;
        p.rd_type     = GPR;
        p.rd_rnid     = rnid_t'(inst[5:0]);
        p.rs1.valid   = s1v;
        p.rs1.regtype = GPR;
        p.rs1.rnid    = rnid_t'(s1r);
        p.rs2.valid   = s2v;
        p.rs2.regtype = GPR;
        p.rs2.rnid    = rnid_t'(s2r);
        return p;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        disp_valid = 1'b0;
        disp_issue = '0;
        for (int b = 0; b < TGT_BUS_SIZE; b++) begin
            ew[b] = '0;
            pw[b] = '0;
        end
        done_valid = 1'b0;
        done_oh    = '0;
        flush      = 1'b0;
    endtask

    task automatic disp(input issue_t p);
        disp_valid = 1'b1;
        disp_issue = p;
    endtask

    task automatic done(input int idx);
        done_valid = 1'b1;
        done_oh    = 8'b1 << idx;
        step();
        done_valid = 1'b0;
        done_oh    = '0;
    endtask

    initial begin
        idle();
        stall = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_count", 64'(cnt), 64'd0);
        chk("rst_ready", 64'(disp_ready), 64'd1);
        chk("rst_index", 64'(iss_idx), 64'd0);
        chk("rst_issue", 64'(iss), 64'd0);

        // three ready ops back to back
        disp(mk(32'h11, 0, 0, 0, 0));
        step();
        disp(mk(32'h12, 0, 0, 0, 0));
        step();
        chk("t1_idx0", 64'(iss_idx), 64'h01);
        chk("t1_inst0", 64'(iss.inst), 64'h11);
        disp(mk(32'h13, 1, 0, 1, 0));
        step();
        idle();
        chk("t1_idx1", 64'(iss_idx), 64'h02);
        step();
        chk("t1_idx2", 64'(iss_idx), 64'h04);
        chk("t1_inst2", 64'(iss.inst), 64'h13);
        step();
        chk("t1_quiet", 64'(iss.valid), 64'd0);
        done(0);
        done(1);
        done(2);

        // older waiter bypassed by younger ready op
        disp(mk(32'h21, 1, 5, 0, 0));
        step();
        disp(mk(32'h22, 0, 0, 0, 0));
        step();
        idle();
        step();
        chk("t2_b_idx", 64'(iss_idx), 64'h02);
        chk("t2_b_inst", 64'(iss.inst), 64'h22);
        done(1);
        pw[0].valid   = 1'b1;
        pw[0].rd_type = FPR;
        pw[0].rd_rnid = 6'd5;
        step();
        idle();
        step();
        step();
        chk("t2_typemiss", 64'(iss.valid), 64'd0);
        pw[0].valid   = 1'b1;
        pw[0].rd_type = GPR;
        pw[0].rd_rnid = 6'd5;
        step();
        idle();
        chk("t2_w1", 64'(iss.valid), 64'd0);
        step();
        chk("t2_a_idx", 64'(iss_idx), 64'h01);
        chk("t2_a_inst", 64'(iss.inst), 64'h21);
        done(0);

        // fill, drop, free entry 3, refill it
        for (int i = 0; i < 8; i++) begin
            disp(mk(32'h300 + 32'(i), 1, 10 + i, 0, 0));
            step();
        end
        idle();
        chk("t3_full_cnt", 64'(cnt), 64'd8);
        chk("t3_full_rdy", 64'(disp_ready), 64'd0);
        disp(mk(32'h399, 0, 0, 0, 0));
        step();
        idle();
        chk("t3_drop_cnt", 64'(cnt), 64'd8);
        step();
        chk("t3_drop_iss", 64'(iss.valid), 64'd0);
        ew[0].valid   = 1'b1;
        ew[0].rd_type = GPR;
        ew[0].rd_rnid = 6'd13;
        step();
        idle();
        step();
        chk("t3_e3_idx", 64'(iss_idx), 64'h08);
        chk("t3_e3_inst", 64'(iss.inst), 64'h303);
        done(3);
        chk("t3_free_rdy", 64'(disp_ready), 64'd1);
        chk("t3_free_cnt", 64'(cnt), 64'd7);
        disp(mk(32'h333, 0, 0, 0, 0));
        step();
        idle();
        step();
        chk("t3_re_idx", 64'(iss_idx), 64'h08);
        chk("t3_re_inst", 64'(iss.inst), 64'h333);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("t3_flush_cnt", 64'(cnt), 64'd0);

        // stall holds back two ready ops
        stall = 1'b1;
        disp(mk(32'h41, 0, 0, 0, 0));
        step();
        chk("t4_st0", 64'(iss.valid), 64'd0);
        disp(mk(32'h42, 0, 0, 0, 0));
        step();
        idle();
        chk("t4_st1", 64'(iss.valid), 64'd0);
        step();
        chk("t4_st2", 64'(iss.valid), 64'd0);
        step();
        chk("t4_st3", 64'(iss.valid), 64'd0);
        stall = 1'b0;
        step();
        chk("t4_idx0", 64'(iss_idx), 64'h01);
        chk("t4_inst0", 64'(iss.inst), 64'h41);
        step();
        chk("t4_idx1", 64'(iss_idx), 64'h02);
        done(0);
        done(1);

        // same-cycle early wakeup on dispatch
        disp(mk(32'h51, 1, 9, 0, 0));
        ew[1].valid   = 1'b1;
        ew[1].rd_type = GPR;
        ew[1].rd_rnid = 6'd9;
        step();
        idle();
        step();
        chk("t5_idx", 64'(iss_idx), 64'h01);
        chk("t5_inst", 64'(iss.inst), 64'h51);
        chk("t5_rs1rdy", 64'(iss.rs1.ready), 64'd1);
        done(0);

        // flush beats a simultaneous dispatch
        for (int i = 0; i < 5; i++) begin
            disp(mk(32'h600 + 32'(i), 1, 20 + i, 0, 0));
            step();
        end
        chk("t6_pre_cnt", 64'(cnt), 64'd5);
        disp(mk(32'h6ff, 0, 0, 0, 0));
        flush = 1'b1;
        step();
        idle();
        chk("t6_cnt", 64'(cnt), 64'd0);
        chk("t6_iss", 64'(iss.valid), 64'd0);
        step();
        chk("t6_cnt2", 64'(cnt), 64'd0);
        chk("t6_iss2", 64'(iss.valid), 64'd0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
